// File: rtl/i2c_target_regfile_if.sv
// I2C pad-side signals of the target: raw SCL/SDA in, open-drain SDA pull-down out.
interface i2c_target_regfile_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport slave  (input  scl_in, input  sda_in, output sda_oe);
    modport master (output scl_in, output sda_in, input  sda_oe);
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target with a 2**ADDR_W byte register file; writes via [addr+W][ptr][data...].
// Optional read path ([addr+R]) is built only when I2C_TARGET_READ_EN is defined.
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR   = 7'h39,
    parameter int         ADDR_W     = 8,
    parameter int         FILTER_LEN = 4,
    parameter int         HOLD_CYC   = 8
) (
    input  logic              clk_ref,
    input  logic              reset_not,
    i2c_target_regfile_if.slave bus,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data,
    output logic              busy,
    output logic [3:0]        state_out
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int FC_W  = $clog2(FILTER_LEN + 1);
    localparam int HC_W  = $clog2(HOLD_CYC + 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6
`ifdef I2C_TARGET_READ_EN
        ,
        RDATA     = 4'd7,
        MACK      = 4'd8
`endif
    } state_t;

    // Index 1 = SCL, index 0 = SDA; filtered lines idle high.
    logic [1:0]           sync1_q, sync2_q, filt_q, filt_p_q;
    logic [1:0][FC_W-1:0] fcnt_q;

    always_ff @(posedge clk_ref or negedge reset_not) begin
        if (!reset_not) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            filt_q   <= 2'b11;
            filt_p_q <= 2'b11;
            fcnt_q   <= '0;
        end else begin
            sync1_q  <= {bus.scl_in, bus.sda_in};
            sync2_q  <= sync1_q;
            filt_p_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FC_W'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    assign scl_f     = filt_q[1];
    assign sda_f     = filt_q[0];
    assign scl_rise  = scl_f & ~filt_p_q[1];
    assign scl_fall  = ~scl_f & filt_p_q[1];
    assign start_det = scl_f & filt_p_q[1] & ~sda_f & filt_p_q[0];
    assign stop_det  = scl_f & filt_p_q[1] & sda_f & ~filt_p_q[0];

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic              ack_q, ack_d, busy_q, busy_d, sda_oe_q, sda_oe_d;
    logic              oe_pend_q, oe_pend_d, oe_at_fall;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic              wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d, byte_in;
    logic              reg_we;
    logic [7:0]        regs_q [DEPTH];
`ifdef I2C_TARGET_READ_EN
    logic              rw_q, rw_d;
`endif

    assign byte_in = {shreg_q[6:0], sda_f};
    assign ptr_inc = ptr_q + 1'b1;

    // Level SDA should take once the post-fall hold time has elapsed.
    always_comb begin
        oe_at_fall = 1'b0;
        case (state_q)
            ADDR_ACK:           oe_at_fall = ack_q;
            PTR_ACK, WDATA_ACK: oe_at_fall = 1'b1;
`ifdef I2C_TARGET_READ_EN
            RDATA:              oe_at_fall = ~shreg_q[7];
`endif
            default:            oe_at_fall = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        ack_d     = ack_q;
        busy_d    = busy_q;
        sda_oe_d  = sda_oe_q;
        oe_pend_d = oe_pend_q;
        hold_d    = hold_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        reg_we    = 1'b0;
`ifdef I2C_TARGET_READ_EN
        rw_d      = rw_q;
`endif
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
            sda_oe_d  = 1'b0;
            hold_d    = '0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
            sda_oe_d  = 1'b0;
            hold_d    = '0;
        end else begin
            if (scl_fall) begin
                hold_d    = HC_W'(HOLD_CYC);
                oe_pend_d = oe_at_fall;
            end else if (hold_q != '0) begin
                hold_d = hold_q - 1'b1;
                if (hold_q == HC_W'(1)) sda_oe_d = oe_pend_q;
            end
            if (scl_rise) begin
                case (state_q)
                    ADDR, PTR, WDATA: begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                ADDR: begin
                                    state_d = ADDR_ACK;
`ifdef I2C_TARGET_READ_EN
                                    ack_d = (byte_in[7:1] == DEV_ADDR);
                                    rw_d  = byte_in[0];
`else
                                    ack_d = (byte_in == {DEV_ADDR, 1'b0});
`endif
                                end
                                PTR: begin
                                    state_d = PTR_ACK;
                                    ptr_d   = byte_in[ADDR_W-1:0];
                                end
                                default: begin
                                    state_d   = WDATA_ACK;
                                    reg_we    = 1'b1;
                                    wr_stb_d  = 1'b1;
                                    wr_addr_d = ptr_q;
                                    wr_data_d = byte_in;
                                    ptr_d     = ptr_inc;
                                end
                            endcase
                        end
                    end
                    ADDR_ACK: begin
                        bit_cnt_d = '0;
                        if (!ack_q) begin
                            state_d = IDLE;
`ifdef I2C_TARGET_READ_EN
                        end else if (rw_q) begin
                            state_d = RDATA;
                            shreg_d = regs_q[ptr_q];
`endif
                        end else begin
                            state_d = PTR;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        state_d   = WDATA;
                        bit_cnt_d = '0;
                    end
`ifdef I2C_TARGET_READ_EN
                    RDATA: begin
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_d = MACK;
                    end
                    MACK: begin
                        bit_cnt_d = '0;
                        if (!sda_f) begin
                            state_d = RDATA;
                            ptr_d   = ptr_inc;
                            shreg_d = regs_q[ptr_inc];
                        end else begin
                            state_d = IDLE;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_ref or negedge reset_not) begin
        if (!reset_not) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            ptr_q     <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            oe_pend_q <= 1'b0;
            hold_q    <= '0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef I2C_TARGET_READ_EN
            rw_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            sda_oe_q  <= sda_oe_d;
            oe_pend_q <= oe_pend_d;
            hold_q    <= hold_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef I2C_TARGET_READ_EN
            rw_q      <= rw_d;
`endif
        end
    end

    always_ff @(posedge clk_ref or negedge reset_not) begin
        if (!reset_not) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
        end else if (reg_we) begin
            regs_q[ptr_q] <= byte_in;
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign wr_stb     = wr_stb_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign dbg_data   = regs_q[dbg_addr];
    assign busy       = busy_q;
    assign state_out  = state_q;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: bit-banged I2C master against i2c_target_regfile with hand-computed expectations.
module tb_i2c_target_regfile;
    localparam int Q = 25;

    logic       clk_ref = 1'b0;
    logic       reset_not = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       wr_stb, busy;
    logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;
    logic [3:0] state_out;

    always #10 clk_ref = ~clk_ref;

    i2c_target_regfile_if bus();
    wire sda_line = sda_m & ~bus.sda_oe;
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_line;

    i2c_target_regfile dut (
        .clk_ref(clk_ref), .reset_not(reset_not), .bus(bus),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy), .state_out(state_out)
    );

    int n_run = 0, n_fail = 0, stb_cnt = 0, oe_hi = 0;
    logic [7:0] stb_addr = 8'h00, stb_data = 8'h00;

    always @(negedge clk_ref) begin
        if (wr_stb) begin
            stb_cnt++;
            stb_addr = wr_addr;
            stb_data = wr_data;
        end
        if (bus.sda_oe) oe_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic hq();
        repeat (Q) @(negedge clk_ref);
    endtask

    task automatic dbg_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, {24'h0, dbg_data}, {24'h0, exp});
    endtask

    // Works both from idle bus and as a repeated START with SCL low.
    task automatic i2c_start();
        sda_m = 1'b1; hq();
        scl_m = 1'b1; hq();
        sda_m = 1'b0; hq();
        scl_m = 1'b0; hq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; hq();
        scl_m = 1'b1; hq();
        sda_m = 1'b1; hq();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_m = b[7-i]; hq();
            scl_m = 1'b1; hq(); hq();
            scl_m = 1'b0; hq();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; hq();
        scl_m = 1'b1; hq();
        ack = ~sda_line; hq();
        scl_m = 1'b0; hq();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            hq();
            scl_m = 1'b1; hq();
            b[i] = sda_line; hq();
            scl_m = 1'b0;
        end
        hq();
        sda_m = nack; hq();
        scl_m = 1'b1; hq(); hq();
        scl_m = 1'b0; hq();
        sda_m = 1'b1;
    endtask

    logic       ack;
    logic [7:0] rb0, rb1;

    initial begin
        #(200000 * 20);
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dbg_addr = 8'h00;
        repeat (5) @(negedge clk_ref);
        chk("rst_oe", bus.sda_oe, 0);
        chk("rst_state", state_out, 0);
        reset_not = 1'b1;
        repeat (5) @(negedge clk_ref);
        chk("idle_busy", busy, 0);
        chk("idle_stb", wr_stb, 0);
        dbg_chk("idle_reg98", 8'h98, 8'h00);

        // Single register write
        i2c_start();
        chk("w1_busy", busy, 1);
        send_byte(8'h72, ack); chk("w1_ack_addr", ack, 1);
        send_byte(8'h98, ack); chk("w1_ack_ptr", ack, 1);
        send_byte(8'h03, ack); chk("w1_ack_data", ack, 1);
        i2c_stop(); hq();
        chk("w1_busy_end", busy, 0);
        chk("w1_stb_cnt", stb_cnt, 1);
        chk("w1_stb_addr", stb_addr, 8'h98);
        chk("w1_stb_data", stb_data, 8'h03);
        dbg_chk("w1_reg98", 8'h98, 8'h03);

        // Wrong device address: ignored entirely
        stb_cnt = 0; oe_hi = 0;
        i2c_start();
        send_byte(8'h70, ack); chk("na_ack", ack, 0);
        send_byte(8'h12, ack);
        send_byte(8'h34, ack);
        i2c_stop(); hq();
        chk("na_oe_cycles", oe_hi, 0);
        chk("na_stb_cnt", stb_cnt, 0);
        dbg_chk("na_reg12", 8'h12, 8'h00);
        dbg_chk("na_reg98", 8'h98, 8'h03);

        // Burst with pointer wrap
        stb_cnt = 0;
        i2c_start();
        send_byte(8'h72, ack); chk("b_ack_addr", ack, 1);
        send_byte(8'hFE, ack);
        send_byte(8'hAA, ack);
        send_byte(8'hBB, ack);
        send_byte(8'hCC, ack); chk("b_ack_last", ack, 1);
        i2c_stop(); hq();
        chk("b_stb_cnt", stb_cnt, 3);
        chk("b_stb_addr", stb_addr, 8'h00);
        dbg_chk("b_regFE", 8'hFE, 8'hAA);
        dbg_chk("b_regFF", 8'hFF, 8'hBB);
        dbg_chk("b_reg00", 8'h00, 8'hCC);

        // Read path (or NACK of read address)
`ifdef I2C_TARGET_READ_EN
        i2c_start();
        send_byte(8'h72, ack); send_byte(8'h10, ack);
        send_byte(8'h5A, ack); send_byte(8'hC3, ack);
        i2c_stop(); hq();
        i2c_start();
        send_byte(8'h72, ack); send_byte(8'h10, ack);
        i2c_start();
        send_byte(8'h73, ack); chk("rd_ack", ack, 1);
        read_byte(1'b0, rb0);
        read_byte(1'b1, rb1);
        chk("rd_byte0", rb0, 8'h5A);
        chk("rd_byte1", rb1, 8'hC3);
        chk("rd_state", state_out, 0);
        i2c_stop(); hq();
`else
        rb0 = 8'h00; rb1 = 8'h00;
        i2c_start();
        send_byte(8'h72, ack); send_byte(8'h10, ack);
        i2c_start();
        send_byte(8'h73, ack); chk("rd_nack", ack, 0);
        chk("rd_state", state_out, 0);
        i2c_stop(); hq();
        chk("rd_oe", bus.sda_oe, 0);
`endif

        // STOP in the middle of a data byte
        stb_cnt = 0;
        i2c_start();
        send_byte(8'h72, ack); send_byte(8'h20, ack);
        send_bits(8'hF0, 4);
        i2c_stop(); hq();
        chk("p_stb_cnt", stb_cnt, 0);
        dbg_chk("p_reg20", 8'h20, 8'h00);
        chk("p_state", state_out, 0);
        chk("p_oe", bus.sda_oe, 0);

        // Asynchronous reset mid-burst
        i2c_start();
        send_byte(8'h72, ack); send_byte(8'h30, ack); send_byte(8'h44, ack);
        send_bits(8'h55, 3);
        reset_not = 1'b0;
        #1;
        chk("r_oe", bus.sda_oe, 0);
        chk("r_busy", busy, 0);
        chk("r_state", state_out, 0);
        chk("r_wr_addr", wr_addr, 0);
        chk("r_wr_data", wr_data, 0);
        dbg_chk("r_reg30", 8'h30, 8'h00);
        dbg_chk("r_regFE", 8'hFE, 8'h00);
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (20) @(negedge clk_ref);
        reset_not = 1'b1;
        hq();
        i2c_start();
        send_byte(8'h72, ack); chk("r_ack_after", ack, 1);
        i2c_stop(); hq();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
